uart_tx_fifo: RTL and testbench

- Bus-side transmit buffer that sits directly upstream of the UART transmitter.
- The CPU writes bytes over the peripheral bus. They are queued in a DEPTH-entry FIFO.
- A drain FSM launches one byte at a time into the transmitter through its one-cycle data-valid strobe, tracking the transmitter's active flag.
- It exposes level/status for polling and a one-cycle interrupt when the queue has fully drained on the line.

---
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                  |
// | Purpose  : Bus-written byte FIFO that drains into a UART transmitter,    |
// |            with a polled status word and a drain-complete interrupt.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        csb_i,
    input  logic        wen_i,
    input  logic [3:0]  wmask_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_dv_o,
    output logic [7:0]  tx_byte_o,
    input  logic        tx_active_i,
    output logic        irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_START = 2'd1;
    localparam logic [1:0] S_WAIT_END   = 2'd2;
    localparam logic [1:0] S_GAP        = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic [1:0]    state;
    logic [GW-1:0] gap_cnt;

    logic bus_wr;
    logic push_req;
    logic ctrl_wr;
    logic flush;
    logic clr_ovf;
    logic full;
    logic empty;
    logic push_ok;
    logic pop;
    logic busy;

    assign bus_wr   = !csb_i && !wen_i;
    assign push_req = bus_wr && wmask_i[0];
    assign ctrl_wr  = bus_wr && wmask_i[1];
    assign flush    = ctrl_wr && data_i[8];
    assign clr_ovf  = ctrl_wr && data_i[9];

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Flush swallows a same-access push entirely, so it never reaches storage.
    assign push_ok = push_req && !full && !flush;
    assign pop     = (state == S_IDLE) && !empty;
    assign busy    = !empty || (state != S_IDLE);

    assign data_o = {20'h00000, busy, overflow, full, empty, 8'(count)};

    // Upper bus lanes carry nothing this block uses.
    logic unused_inputs;
    assign unused_inputs = ^{data_i[31:10], wmask_i[3:2]};

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end
            if (push_req && full && !flush) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            tx_dv_o   <= 1'b0;
            tx_byte_o <= 8'h00;
            irq_o     <= 1'b0;
        end else begin
            tx_dv_o <= 1'b0;
            irq_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        tx_byte_o <= mem[rd_ptr];
                        tx_dv_o   <= 1'b1;
                        state     <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (tx_active_i) begin
                        state <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    // Emptiness is judged before any push landing on this edge.
                    if (!tx_active_i) begin
                        gap_cnt <= GAP_LOAD;
                        irq_o   <= empty;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_fifo                                               |
// | Purpose  : Self-checking bench for uart_tx_fifo with a queue-based model |
// |            and a simple transmitter model.                               |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DEPTH   = 16;
    localparam int GAP     = 2;
    localparam int ACT_LEN = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csb = 1'b1;
    logic        wen = 1'b1;
    logic [3:0]  wmask = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] status;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active = 1'b0;
    logic        irq;

    uart_tx_fifo #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .csb_i       (csb),
        .wen_i       (wen),
        .wmask_i     (wmask),
        .data_i      (wdata),
        .data_o      (status),
        .tx_dv_o     (tx_dv),
        .tx_byte_o   (tx_byte),
        .tx_active_i (tx_active),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Reference model: pending bytes, sticky overflow, transmitter bookkeeping.
    logic [7:0] mq[$];
    logic [7:0] sent_log[$];
    logic       m_ovf = 1'b0;
    logic       hold = 1'b0;
    bit         inflight = 0;
    int         busy_cnt = 0;
    int         irq_edge = -1;
    int         gap_edge = -1;
    int         fall_edge = -1;
    int         fall_count = 0;
    int         launch_edge = -1;
    int         irq_seen = 0;
    int         accepted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[7:0] = 8'(mq.size());
        s[8]   = (mq.size() == 0);
        s[9]   = (mq.size() == DEPTH);
        s[10]  = m_ovf;
        return s;
    endfunction

    function automatic void model_access(input logic cs_n, input logic we_n,
                                         input logic [3:0] m, input logic [31:0] d);
        bit acc;
        bit fl;
        acc = !cs_n && !we_n;
        fl  = acc && m[1] && d[8];
        if (acc && m[1] && d[9]) m_ovf = 1'b0;
        if (acc && m[0] && !fl) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else begin
                mq.push_back(d[7:0]);
                accepted++;
            end
        end
        if (fl) mq.delete();
    endfunction

    always @(negedge clk) begin : monitor
        logic [7:0] exp_b;
        if (reset) begin
            mq.delete();
            m_ovf    = 1'b0;
            inflight = 0;
            irq_edge = -1;
            gap_edge = -1;
        end else if (tx_dv) begin
            launch_edge = cyc;
            sent_log.push_back(tx_byte);
            if (gap_edge >= 0) begin
                check("launch_gap_edge", 32'(cyc), 32'(gap_edge));
                gap_edge = -1;
            end
            compared++;
            if (mq.size() == 0) begin
                mismatched++;
                $display("FAIL launch_order: launched %h, expected no launch (queue empty)", tx_byte);
            end else begin
                exp_b = mq.pop_front();
                if (tx_byte !== exp_b) begin
                    mismatched++;
                    $display("FAIL launch_order: got %h, expected %h", tx_byte, exp_b);
                end
            end
        end
        // Transmitter: active from the cycle after the strobe for ACT_LEN cycles.
        if (tx_dv) begin
            tx_active = 1'b1;
            busy_cnt  = ACT_LEN;
            inflight  = 1;
        end else if (hold) begin
            tx_active = 1'b1;
        end else if (tx_active) begin
            if (busy_cnt <= 1) begin
                tx_active = 1'b0;
                busy_cnt  = 0;
                fall_edge = cyc + 1;
                fall_count++;
                if (inflight && !reset) begin
                    if (mq.size() == 0) irq_edge = cyc + 1;
                    else gap_edge = cyc + 1 + GAP + 1;
                end
                inflight = 0;
            end else begin
                busy_cnt--;
            end
        end
        if (!reset) begin
            if (irq) irq_seen++;
            check("irq_pulse", 32'(irq), 32'(cyc == irq_edge));
            check("status_vs_model", status & ~32'h800, model_status());
        end
    end

    task automatic bus_write(input logic cs_n, input logic we_n,
                             input logic [3:0] m, input logic [31:0] d);
        @(negedge clk); #1;
        csb = cs_n; wen = we_n; wmask = m; wdata = d;
        model_access(cs_n, we_n, m, d);
        @(posedge clk); #1;
        csb = 1'b1; wen = 1'b1; wmask = 4'h0; wdata = 32'h0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((mq.size() != 0 || inflight || tx_active) && n < limit) begin
            @(negedge clk); #1;
            n++;
        end
        compared++;
        if (n >= limit) begin
            mismatched++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
        end
        repeat (GAP + 3) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic        cs_n;
        logic        we_n;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int irq0;
        int sent0;
        int acc0;
        int e0;
        int fc;
        int n;

        // Status-only accesses while the FSM sits in WAIT_END with an empty queue.
        tbl[0] = '{1'b0, 1'b0, 4'h1, 32'h00000021, 32'h00000801};
        tbl[1] = '{1'b0, 1'b0, 4'h1, 32'h00000022, 32'h00000802};
        tbl[2] = '{1'b0, 1'b0, 4'h2, 32'h00000200, 32'h00000802};
        tbl[3] = '{1'b0, 1'b0, 4'h0, 32'h000001FF, 32'h00000802};
        tbl[4] = '{1'b1, 1'b0, 4'h1, 32'h00000023, 32'h00000802};
        tbl[5] = '{1'b0, 1'b1, 4'h3, 32'h00000123, 32'h00000802};
        tbl[6] = '{1'b0, 1'b0, 4'h3, 32'h000001AA, 32'h00000900};
        tbl[7] = '{1'b0, 1'b0, 4'h1, 32'h00000033, 32'h00000801};
        tbl[8] = '{1'b0, 1'b0, 4'h3, 32'h00000034, 32'h00000802};
        tbl[9] = '{1'b0, 1'b0, 4'h2, 32'h00000100, 32'h00000900};

        #1;
        check("reset_status", status, 32'h00000100);
        check("reset_tx_dv", 32'(tx_dv), 32'h0);
        check("reset_tx_byte", 32'(tx_byte), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte: launch latency, byte value and one drain interrupt.
        irq0 = irq_seen;
        sent0 = sent_log.size();
        bus_write(1'b0, 1'b0, 4'h1, 32'h00000041);
        e0 = cyc;
        n = 0;
        while (sent_log.size() == sent0 && n < 10) begin @(negedge clk); #1; n++; end
        check("single_launch_edge", 32'(launch_edge), 32'(e0 + 1));
        check("single_byte", 32'(tx_byte), 32'h41);
        wait_idle(60);
        check("single_irq_count", 32'(irq_seen - irq0), 32'd1);
        check("single_idle_status", status, 32'h00000100);

        // Five bytes back to back.
        irq0 = irq_seen;
        sent0 = sent_log.size();
        for (int i = 1; i <= 5; i++) bus_write(1'b0, 1'b0, 4'h1, 32'(i));
        wait_idle(200);
        check("burst_sent_count", 32'(sent_log.size() - sent0), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (sent0 + i < sent_log.size())
                check("burst_order", 32'(sent_log[sent0 + i]), 32'(i + 1));
        end
        check("burst_irq_count", 32'(irq_seen - irq0), 32'd1);

        // Asynchronous reset mid-transmission.
        for (int i = 0; i < 3; i++) bus_write(1'b0, 1'b0, 4'h1, 32'(8'h61 + i));
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_status", status, 32'h00000100);
        check("midreset_tx_dv", 32'(tx_dv), 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        n = 0;
        while (tx_active && n < 40) begin @(negedge clk); #1; n++; end
        repeat (GAP + 3) @(negedge clk);
        #1;
        check("post_reset_status", status, 32'h00000100);

        // Park the FSM in WAIT_END with the transmitter held busy.
        hold = 1'b1;
        bus_write(1'b0, 1'b0, 4'h1, 32'h0000005A);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bus_write(tbl[i].cs_n, tbl[i].we_n, tbl[i].mask, tbl[i].data);
            check($sformatf("table[%0d]", i), status, tbl[i].exp);
        end

        // Overfill: DEPTH+2 pushes while nothing drains.
        for (int i = 0; i < DEPTH + 2; i++) bus_write(1'b0, 1'b0, 4'h1, 32'($urandom_range(0, 255)));
        check("overfill_status", status, 32'h00000E10);
        bus_write(1'b0, 1'b0, 4'h2, 32'h00000200);
        check("overflow_clear", status, 32'h00000A10);

        // Push while full on the very edge the FSM pops.
        fc = fall_count;
        hold = 1'b0;
        n = 0;
        while (fall_count == fc && n < 50) begin @(negedge clk); #1; n++; end
        check("release_fall_seen", 32'(fall_count - fc), 32'd1);
        while (cyc < fall_edge + GAP) begin @(negedge clk); #1; end
        csb = 1'b0; wen = 1'b0; wmask = 4'h1; wdata = 32'h000000EE;
        model_access(1'b0, 1'b0, 4'h1, 32'h000000EE);
        @(posedge clk); #1;
        csb = 1'b1; wen = 1'b1; wmask = 4'h0; wdata = 32'h0;
        check("full_pop_collision", status, 32'h00000C0F);
        bus_write(1'b0, 1'b0, 4'h2, 32'h00000200);
        wait_idle(DEPTH * 20 + 50);

        // Flush with a simultaneous push while a byte is in flight.
        hold = 1'b1;
        irq0 = irq_seen;
        sent0 = sent_log.size();
        bus_write(1'b0, 1'b0, 4'h1, 32'h000000C1);
        bus_write(1'b0, 1'b0, 4'h1, 32'h000000C2);
        bus_write(1'b0, 1'b0, 4'h1, 32'h000000C3);
        repeat (2) @(negedge clk);
        bus_write(1'b0, 1'b0, 4'h3, 32'h000001AA);
        check("flush_status", status, 32'h00000900);
        hold = 1'b0;
        wait_idle(60);
        check("flush_sent_count", 32'(sent_log.size() - sent0), 32'd1);
        check("flush_inflight_byte", 32'(sent_log[sent_log.size() - 1]), 32'hC1);
        check("flush_irq_count", 32'(irq_seen - irq0), 32'd1);

        // Randomized stream across several pointer wraps.
        sent0 = sent_log.size();
        acc0 = accepted;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            n = 0;
            while (mq.size() == DEPTH && ($urandom_range(0, 3) != 0) && n < 100) begin
                @(negedge clk); #1; n++;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus_write(1'b0, 1'b0, ($urandom_range(0, 7) == 0) ? 4'h3 : 4'h1,
                      {22'h0, 1'b1, 1'b0, 8'($urandom_range(0, 255))});
        end
        wait_idle(3 * DEPTH * 20 + 100);
        check("stream_all_sent", 32'(sent_log.size() - sent0), 32'(accepted - acc0));
        check("stream_busy_after_drain", 32'(status[11]), 32'h0);
        check("stream_count_after_drain", 32'(status[7:0]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
